alu8_seq_ctrl: RTL and testbench
================================

ALU8_SEQ_CTRL -- requirements
Module: alu8_seq_ctrl

Interface
REQ-001 Parameters: none; widths fixed as listed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  requester presents an 8-bit operation.
REQ-005 req_ready  output  1  block can accept an operation this cycle.
REQ-006 req_a  input  8  operand A.
REQ-007 req_b  input  8  operand B.
REQ-008 req_op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT(A); 110/111 illegal.
REQ-009 req_cin  input  1  carry-in (ADD) / borrow-in (SUB); ignored otherwise.
REQ-010 alu_a  output  4  nibble A to the 4-bit ALU.
REQ-011 alu_b  output  4  nibble B to the 4-bit ALU.
REQ-012 alu_opcode  output  3  opcode to the 4-bit ALU.
REQ-013 alu_cin  output  1  carry-in to the 4-bit ALU.
REQ-014 alu_result  input  4  combinational ALU result, valid in the same cycle.
REQ-015 alu_cout  input  1  combinational ALU carry/borrow out.
REQ-016 rsp_valid  output  1  response held valid until accepted.
REQ-017 rsp_ready  input  1  consumer accepts response.
REQ-018 rsp_result  output  8  8-bit result.
REQ-019 rsp_carry  output  1  high-nibble alu_cout for ADD/SUB; 0 otherwise.
REQ-020 rsp_zero  output  1  rsp_result == 0x00.
REQ-021 rsp_neg  output  1  rsp_result[7].
REQ-022 rsp_ovf  output  1  signed overflow; 0 for logical ops.
REQ-023 rsp_err  output  1  illegal opcode accepted.

Function
REQ-024 FSM states IDLE, LO, HI, DONE; req_ready = 1 only in IDLE; rsp_valid = 1 only in DONE.
REQ-025 IDLE: on req_valid & req_ready, capture req_a/req_b/req_op/req_cin; legal op -> LO, illegal op -> DONE with rsp_err=1, rsp_result=0x00, all other flags 0 except rsp_zero=1.
REQ-026 LO: drive alu_a=A[3:0], alu_b=B[3:0], alu_opcode=op, alu_cin=cin (0 for logical ops); capture alu_result into result[3:0] and alu_cout into internal carry; -> HI.
REQ-027 HI: drive alu_a=A[7:4], alu_b=B[7:4], alu_opcode=op, alu_cin=captured low carry for ADD/SUB, 0 otherwise; capture result[7:4], rsp_carry; compute flags; -> DONE.
REQ-028 DONE: outputs rsp_* held stable; on rsp_ready -> IDLE same edge; no new request accepted while in DONE.
REQ-029 Latency legal op: accept edge at cycle 0, rsp_valid asserted from cycle 3; illegal op: rsp_valid from cycle 1.
REQ-030 In IDLE and DONE, alu_a, alu_b, alu_opcode, alu_cin driven 0.
REQ-031 Overflow ADD: A[7]==B[7] and R[7]!=A[7]; SUB: A[7]!=B[7] and R[7]!=A[7]; SUB carry = borrow out of bit 7.
REQ-032 Arithmetic modulo 256; carry/borrow from bit 7 reported only in rsp_carry.
REQ-033 Operand inputs changing after acceptance shall not affect the operation in flight.

Reset
REQ-034 On rst=1 at a clock edge: state IDLE, req_ready=1, rsp_valid=0, rsp_result=0x00, all rsp flags 0, alu_* outputs 0, captured operands cleared.
REQ-035 rst overrides any state including LO, HI and DONE; in-flight operation discarded, no response produced.

Verification
REQ-036 ADD A=0x7F B=0x01 cin=0 -> cycle 3 rsp_result=0x80, carry=0, ovf=1, neg=1, zero=0, err=0.
REQ-037 SUB A=0x00 B=0x01 cin=0 -> rsp_result=0xFF, carry=1, neg=1, ovf=0; HI-cycle alu_cin=1.
REQ-038 ADD A=0xFF B=0x00 cin=1 -> rsp_result=0x00, carry=1, zero=1, ovf=0.
REQ-039 XOR A=0xA5 B=0xFF with rsp_ready low 5 cycles -> rsp_result=0x5A stable, req_ready=0 throughout; rsp_ready high -> IDLE next cycle.
REQ-040 req_op=110 -> cycle 1 rsp_valid=1, rsp_err=1, rsp_result=0x00, rsp_zero=1.
REQ-041 rst asserted in HI -> next cycle IDLE, req_ready=1, rsp_valid=0; a following ADD 0x12+0x34 returns 0x46.

Source files
------------

// File: rtl/alu8_seq_ctrl.sv
// Sequences an 8-bit operation through an external 4-bit ALU, low nibble then high nibble,
// and presents the result with flags on a valid/ready response port.
module alu8_seq_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic [2:0] req_op,
    input  logic       req_cin,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_opcode,
    output logic       alu_cin,
    input  logic [3:0] alu_result,
    input  logic       alu_cout,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic       rsp_carry,
    output logic       rsp_zero,
    output logic       rsp_neg,
    output logic       rsp_ovf,
    output logic       rsp_err
);

    localparam int unsigned DW = 8;
    localparam int unsigned NW = 4;
    localparam int unsigned OW = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [OW-1:0] OP_ADD = 3'd0;
    localparam logic [OW-1:0] OP_SUB = 3'd1;
    localparam logic [OW-1:0] OP_NOT = 3'd5;

    function automatic logic is_arith(input logic [OW-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic is_legal(input logic [OW-1:0] op);
        return op <= OP_NOT;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [NW-1:0] a_hi_q, a_hi_d, b_hi_q, b_hi_d, res_lo_q, res_lo_d;
    logic [OW-1:0] op_q, op_d;
    logic          req_ready_d, rsp_valid_d;
    logic [NW-1:0] alu_a_d, alu_b_d;
    logic [OW-1:0] alu_opcode_d;
    logic          alu_cin_d;
    logic [DW-1:0] rsp_result_d;
    logic          rsp_carry_d, rsp_zero_d, rsp_neg_d, rsp_ovf_d, rsp_err_d;
    logic [DW-1:0] full_res_c;

    // Only the high operand nibbles need holding; the low nibbles live in the alu_* registers during LO.
    assign full_res_c = {alu_result, res_lo_q};

    always_comb begin
        state_d      = state_q;
        a_hi_d       = a_hi_q;
        b_hi_d       = b_hi_q;
        op_d         = op_q;
        res_lo_d     = res_lo_q;
        req_ready_d  = 1'b0;
        rsp_valid_d  = 1'b0;
        alu_a_d      = '0;
        alu_b_d      = '0;
        alu_opcode_d = '0;
        alu_cin_d    = 1'b0;
        rsp_result_d = rsp_result;
        rsp_carry_d  = rsp_carry;
        rsp_zero_d   = rsp_zero;
        rsp_neg_d    = rsp_neg;
        rsp_ovf_d    = rsp_ovf;
        rsp_err_d    = rsp_err;
        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready) begin
                    req_ready_d = 1'b0;
                    a_hi_d      = req_a[7:4];
                    b_hi_d      = req_b[7:4];
                    op_d        = req_op;
                    if (is_legal(req_op)) begin
                        state_d      = ST_LO;
                        alu_a_d      = req_a[3:0];
                        alu_b_d      = req_b[3:0];
                        alu_opcode_d = req_op;
                        alu_cin_d    = is_arith(req_op) & req_cin;
                    end else begin
                        state_d      = ST_DONE;
                        rsp_valid_d  = 1'b1;
                        rsp_result_d = '0;
                        rsp_carry_d  = 1'b0;
                        rsp_zero_d   = 1'b1;
                        rsp_neg_d    = 1'b0;
                        rsp_ovf_d    = 1'b0;
                        rsp_err_d    = 1'b1;
                    end
                end
            end
            ST_LO: begin
                // Low-nibble carry is held in alu_cin for the high-nibble pass.
                state_d      = ST_HI;
                res_lo_d     = alu_result;
                alu_a_d      = a_hi_q;
                alu_b_d      = b_hi_q;
                alu_opcode_d = op_q;
                alu_cin_d    = is_arith(op_q) & alu_cout;
            end
            ST_HI: begin
                state_d      = ST_DONE;
                rsp_valid_d  = 1'b1;
                rsp_result_d = full_res_c;
                rsp_carry_d  = is_arith(op_q) & alu_cout;
                rsp_zero_d   = (full_res_c == 8'h00);
                rsp_neg_d    = full_res_c[7];
                rsp_err_d    = 1'b0;
                if (op_q == OP_ADD)
                    rsp_ovf_d = (a_hi_q[3] == b_hi_q[3]) && (full_res_c[7] != a_hi_q[3]);
                else if (op_q == OP_SUB)
                    rsp_ovf_d = (a_hi_q[3] != b_hi_q[3]) && (full_res_c[7] != a_hi_q[3]);
                else
                    rsp_ovf_d = 1'b0;
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    req_ready_d = 1'b1;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            a_hi_q     <= '0;
            b_hi_q     <= '0;
            op_q       <= '0;
            res_lo_q   <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            alu_cin    <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_neg    <= 1'b0;
            rsp_ovf    <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_hi_q     <= a_hi_d;
            b_hi_q     <= b_hi_d;
            op_q       <= op_d;
            res_lo_q   <= res_lo_d;
            req_ready  <= req_ready_d;
            rsp_valid  <= rsp_valid_d;
            alu_a      <= alu_a_d;
            alu_b      <= alu_b_d;
            alu_opcode <= alu_opcode_d;
            alu_cin    <= alu_cin_d;
            rsp_result <= rsp_result_d;
            rsp_carry  <= rsp_carry_d;
            rsp_zero   <= rsp_zero_d;
            rsp_neg    <= rsp_neg_d;
            rsp_ovf    <= rsp_ovf_d;
            rsp_err    <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_alu8_seq_ctrl.sv
// Bench for alu8_seq_ctrl: models the external 4-bit ALU, keeps a transaction-level reference
// of the 8-bit result, and checks handshake, ALU drive and response every cycle.
module tb_alu8_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_a = '0;
    logic [7:0] req_b = '0;
    logic [2:0] req_op = '0;
    logic       req_cin = 1'b0;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_opcode;
    logic       alu_cin;
    logic [3:0] alu_result;
    logic       alu_cout;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_result;
    logic       rsp_carry, rsp_zero, rsp_neg, rsp_ovf, rsp_err;

    int n_chk  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    alu8_seq_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_cin(req_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .rsp_neg(rsp_neg), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // External 4-bit ALU
    int alu_t;
    always_comb begin
        alu_t      = 0;
        alu_result = '0;
        alu_cout   = 1'b0;
        case (alu_opcode)
            3'd0: begin
                alu_t      = int'(alu_a) + int'(alu_b) + int'(alu_cin);
                alu_result = alu_t[3:0];
                alu_cout   = (alu_t > 15);
            end
            3'd1: begin
                alu_t      = int'(alu_a) - int'(alu_b) - int'(alu_cin);
                alu_result = alu_t[3:0];
                alu_cout   = (alu_t < 0);
            end
            3'd2: alu_result = alu_a & alu_b;
            3'd3: alu_result = alu_a | alu_b;
            3'd4: alu_result = alu_a ^ alu_b;
            3'd5: alu_result = ~alu_a;
            default: alu_result = '0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Full 8-bit reference: {result, carry, zero, neg, ovf, err}
    function automatic logic [12:0] ref_rsp(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op, input logic cin);
        int s;
        logic [7:0] r;
        logic c, v, e;
        s = 0; r = '0; c = 1'b0; v = 1'b0; e = 1'b0;
        case (op)
            3'd0: begin
                s = int'(a) + int'(b) + int'(cin);
                r = s[7:0]; c = (s > 255);
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            3'd1: begin
                s = int'(a) - int'(b) - int'(cin);
                r = s[7:0]; c = (s < 0);
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            default: e = 1'b1;
        endcase
        return {r, c, (r == 8'h00), r[7], v, e};
    endfunction

    // Expected ALU drive {alu_a, alu_b, alu_opcode, alu_cin} for a phase of the operation
    function automatic logic [11:0] ref_alu(input int ph, input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op, input logic cin);
        logic arith, lowc;
        arith = (op == 3'd0) || (op == 3'd1);
        if (op == 3'd0) lowc = (int'(a[3:0]) + int'(b[3:0]) + int'(cin)) > 15;
        else            lowc = (int'(a[3:0]) - int'(b[3:0]) - int'(cin)) < 0;
        case (ph)
            1:       return {a[3:0], b[3:0], op, arith & cin};
            2:       return {a[7:4], b[7:4], op, arith & lowc};
            default: return 12'h000;
        endcase
    endfunction

    // Phase of the operation in flight: 0 waiting, 1 low nibble, 2 high nibble, 3 responding
    int         m_ph = 0;
    logic [7:0] m_a = '0, m_b = '0;
    logic [2:0] m_op = '0;
    logic       m_cin = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_ph <= 0;
        end else begin
            case (m_ph)
                0: if (req_valid) begin
                    m_a <= req_a; m_b <= req_b; m_op <= req_op; m_cin <= req_cin;
                    m_ph <= (req_op > 3'd5) ? 3 : 1;
                end
                1: m_ph <= 2;
                2: m_ph <= 3;
                default: if (rsp_ready) m_ph <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("req_ready", 32'(req_ready), 32'(m_ph == 0));
            check("rsp_valid", 32'(rsp_valid), 32'(m_ph == 3));
            check("alu_drive", 32'({alu_a, alu_b, alu_opcode, alu_cin}),
                  32'(ref_alu(m_ph, m_a, m_b, m_op, m_cin)));
            if (m_ph == 3)
                check("rsp_fields", 32'({rsp_result, rsp_carry, rsp_zero, rsp_neg, rsp_ovf, rsp_err}),
                      32'(ref_rsp(m_a, m_b, m_op, m_cin)));
        end
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic cin);
        @(negedge clk);
        req_valid = 1'b1; req_a = a; req_b = b; req_op = op; req_cin = cin;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a   = 8'($urandom);
        req_b   = 8'($urandom);
        req_op  = 3'($urandom_range(0, 7));
        req_cin = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_rsp(output int lat, output logic hic);
        lat = 0;
        hic = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 2) hic = alu_cin;
        end while (rsp_valid !== 1'b1 && lat < 8);
    endtask

    task automatic release_rsp();
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic       cin;
        int         hold;
        logic [7:0] res;
        logic [4:0] fl;   // {carry, zero, neg, ovf, err}
        int         lat;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int   lat;
        logic hic;
        vecs[0]  = '{8'h7F, 8'h01, 3'd0, 1'b0, 0, 8'h80, 5'b00110, 3};
        vecs[1]  = '{8'h00, 8'h01, 3'd1, 1'b0, 0, 8'hFF, 5'b10100, 3};
        vecs[2]  = '{8'hFF, 8'h00, 3'd0, 1'b1, 0, 8'h00, 5'b11000, 3};
        vecs[3]  = '{8'hA5, 8'hFF, 3'd4, 1'b0, 5, 8'h5A, 5'b00000, 3};
        vecs[4]  = '{8'h3C, 8'hC3, 3'd6, 1'b1, 0, 8'h00, 5'b01001, 1};
        vecs[5]  = '{8'hF0, 8'h3C, 3'd2, 1'b1, 0, 8'h30, 5'b00000, 3};
        vecs[6]  = '{8'h0F, 8'h80, 3'd3, 1'b0, 0, 8'h8F, 5'b00100, 3};
        vecs[7]  = '{8'h55, 8'h12, 3'd5, 1'b1, 0, 8'hAA, 5'b00100, 3};
        vecs[8]  = '{8'h80, 8'h01, 3'd1, 1'b0, 0, 8'h7F, 5'b00010, 3};
        vecs[9]  = '{8'h10, 8'h05, 3'd1, 1'b1, 0, 8'h0A, 5'b00000, 3};
        vecs[10] = '{8'h80, 8'h80, 3'd0, 1'b0, 0, 8'h00, 5'b11010, 3};
        vecs[11] = '{8'hFF, 8'hFF, 3'd7, 1'b0, 0, 8'h00, 5'b01001, 1};
        vecs[12] = '{8'h0F, 8'h01, 3'd0, 1'b0, 0, 8'h10, 5'b00000, 3};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp", 32'({rsp_result, rsp_carry, rsp_zero, rsp_neg, rsp_ovf, rsp_err}), 32'd0);
        check("reset_alu", 32'({alu_a, alu_b, alu_opcode, alu_cin}), 32'd0);
        rst = 1'b0;
        started = 1'b1;

        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cin);
            wait_rsp(lat, hic);
            check("latency", 32'(lat), 32'(vecs[i].lat));
            check("result", 32'(rsp_result), 32'(vecs[i].res));
            check("flags", 32'({rsp_carry, rsp_zero, rsp_neg, rsp_ovf, rsp_err}), 32'(vecs[i].fl));
            if (i == 1) check("sub_hi_cin", 32'(hic), 32'd1);
            for (int k = 0; k < vecs[i].hold; k++) begin
                @(negedge clk);
                req_valid = 1'b1;
                check("hold_result", 32'(rsp_result), 32'(vecs[i].res));
                check("hold_req_ready", 32'(req_ready), 32'd0);
            end
            release_rsp();
        end

        // Reset while the high nibble is being processed
        issue(8'h9C, 8'h47, 3'd0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_hi_req_ready", 32'(req_ready), 32'd1);
        check("rst_hi_rsp_valid", 32'(rsp_valid), 32'd0);

        issue(8'h12, 8'h34, 3'd0, 1'b0);
        wait_rsp(lat, hic);
        check("post_rst_latency", 32'(lat), 32'd3);
        check("post_rst_result", 32'(rsp_result), 32'h46);
        release_rsp();

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
